// File: rtl/uart_rx_parity_check.sv
// uart_rx_parity_check
//   Serial receiver sharing the transmitter's baud clock. One bit is sampled
//   per rising edge of CLK_Baudin. It deframes start, DATA_W data bits (LSB
//   first) and one parity bit, checks parity, and raises Flag_out on a
//   mismatch so the transmitter can be asked to resend.
//
// Ports
//   CLK_Baudin    in   baud clock, one bit sampled per rising edge
//   RstTx         in   asynchronous active-high reset
//   RxSerialData  in   serial line, idle high
//   DataOut       out  last word received with good parity
//   DoneRx        out  one-cycle pulse when DataOut updates
//   Flag_out      out  parity-error flag, held until the next start bit
//   RxBusy        out  high while in DATA or PAR
//   ErrCount      out  saturating parity-error count
module uart_rx_parity_check #(
  parameter int DATA_W     = 32,
  parameter int PARITY_ODD = 0,
  parameter int ERR_W      = 8
) (
  input  logic              CLK_Baudin,
  input  logic              RstTx,
  input  logic              RxSerialData,
  output logic [DATA_W-1:0] DataOut,
  output logic              DoneRx,
  output logic              Flag_out,
  output logic              RxBusy,
  output logic [ERR_W-1:0]  ErrCount
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic              PAR_INV  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    WAIT_IDLE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  bitcnt;
  logic              exp_par;

  assign exp_par = (^shift) ^ PAR_INV;

  always_ff @(posedge CLK_Baudin or posedge RstTx) begin
    if (RstTx) begin
      state    <= IDLE;
      shift    <= '0;
      bitcnt   <= '0;
      DataOut  <= '0;
      DoneRx   <= 1'b0;
      Flag_out <= 1'b0;
      RxBusy   <= 1'b0;
      ErrCount <= '0;
    end else begin
      DoneRx <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!RxSerialData) begin
            state    <= DATA;
            bitcnt   <= '0;
            Flag_out <= 1'b0;
            RxBusy   <= 1'b1;
          end
        end
        DATA: begin
          // LSB arrives first, so shift right: bit 0 ends up holding it.
          shift  <= {RxSerialData, shift[DATA_W-1:1]};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            state <= PAR;
          end
        end
        PAR: begin
          if (RxSerialData == exp_par) begin
            DataOut <= shift;
            DoneRx  <= 1'b1;
          end else begin
            Flag_out <= 1'b1;
            if (ErrCount != '1) begin
              ErrCount <= ErrCount + 1'b1;
            end
          end
          RxBusy <= 1'b0;
          state  <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          // A low line here is a parity bit held over; only a high returns.
          if (RxSerialData) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parity_check.sv
module tb_uart_rx_parity_check;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic        rx;
  logic [31:0] DataOut;
  logic        DoneRx;
  logic        Flag_out;
  logic        RxBusy;
  logic [7:0]  ErrCount;
  logic [31:0] s_DataOut;
  logic        s_DoneRx;
  logic        s_Flag_out;
  logic        s_RxBusy;
  logic [1:0]  s_ErrCount;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    bit          is_flag;
    logic [31:0] data;
    logic [7:0]  err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_dout = '0;
  logic [7:0]  exp_err  = '0;
  logic        prev_flag = 1'b0;

  uart_rx_parity_check #(.DATA_W(32), .PARITY_ODD(0), .ERR_W(8)) dut (
    .CLK_Baudin   (clk),
    .RstTx        (rst),
    .RxSerialData (rx),
    .DataOut      (DataOut),
    .DoneRx       (DoneRx),
    .Flag_out     (Flag_out),
    .RxBusy       (RxBusy),
    .ErrCount     (ErrCount)
  );

  uart_rx_parity_check #(.DATA_W(32), .PARITY_ODD(0), .ERR_W(2)) dut_sat (
    .CLK_Baudin   (clk),
    .RstTx        (rst2),
    .RxSerialData (rx),
    .DataOut      (s_DataOut),
    .DoneRx       (s_DoneRx),
    .Flag_out     (s_Flag_out),
    .RxBusy       (s_RxBusy),
    .ErrCount     (s_ErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever DoneRx pulses or Flag_out rises.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (DoneRx && Flag_out) check("done_flag_exclusive", 32'd1, 32'd0);
      if (DoneRx || (Flag_out && !prev_flag)) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("event_kind_flag", {31'd0, Flag_out}, {31'd0, e.is_flag});
          check("event_dataout", DataOut, e.data);
          check("event_errcount", {24'd0, ErrCount}, {24'd0, e.err});
        end
      end
    end
    prev_flag = Flag_out;
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
  endtask

  // good: hand-determined whether parity bit p matches even parity of d.
  task automatic send_frame(input logic [31:0] d, input logic p, input bit good);
    exp_t e;
    if (good) begin
      exp_dout = d;
      e = '{is_flag: 1'b0, data: d, err: exp_err};
    end else begin
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      e = '{is_flag: 1'b1, data: exp_dout, err: exp_err};
    end
    sb.push_back(e);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 32; i++) begin
      send_bit(d[i]);
      if (i == 0) begin
        check("busy_in_frame", {31'd0, RxBusy}, 32'd1);
        check("flag_clear_on_start", {31'd0, Flag_out}, 32'd0);
      end
    end
    send_bit(p);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_bit(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] sat_exp [5];
  logic [31:0] bad_deadbeef;

  initial begin
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    rst = 1'b1; rst2 = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dataout", DataOut, 32'd0);
    check("reset_donerx", {31'd0, DoneRx}, 32'd0);
    check("reset_flag", {31'd0, Flag_out}, 32'd0);
    check("reset_busy", {31'd0, RxBusy}, 32'd0);
    check("reset_errcount", {24'd0, ErrCount}, 32'd0);
    rst = 1'b0;
    idle(2);

    // 0xA5A5A5A5 has 16 ones: even parity bit 0.
    send_frame(32'hA5A5A5A5, 1'b0, 1'b1);
    idle(3);
    // 0x00000001 needs parity 1; 0 is wrong.
    send_frame(32'h00000001, 1'b0, 1'b0);
    idle(3);
    check("flag_held_in_idle", {31'd0, Flag_out}, 32'd1);
    check("dataout_kept_after_bad", DataOut, 32'hA5A5A5A5);

    // 0xDEADBEEF has 24 ones: parity 0. Corrupt one bit, then resend.
    bad_deadbeef = 32'hDEADBEEF ^ 32'h0000_0400;
    send_frame(bad_deadbeef, 1'b0, 1'b0);
    send_bit(1'b0); // transmitter holding parity a second cycle
    idle(3);
    check("flag_held_until_resend", {31'd0, Flag_out}, 32'd1);
    send_frame(32'hDEADBEEF, 1'b0, 1'b1);
    idle(2);
    check("resend_dataout", DataOut, 32'hDEADBEEF);

    // Back-to-back with exactly one high cycle; 0x12345678 has 13 ones.
    send_frame(32'h12345678, 1'b1, 1'b1);
    send_bit(1'b1);
    send_frame(32'hA5A5A5A5, 1'b0, 1'b1);
    // Line held low after parity: must stay in WAIT_IDLE.
    repeat (5) send_bit(1'b0);
    check("hold_low_not_busy", {31'd0, RxBusy}, 32'd0);
    idle(2);

    // Reset at data bit 10 abandons the frame.
    send_bit(1'b0);
    for (int unsigned i = 0; i < 10; i++) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_dataout", DataOut, 32'd0);
    check("midreset_busy", {31'd0, RxBusy}, 32'd0);
    check("midreset_flag", {31'd0, Flag_out}, 32'd0);
    check("midreset_errcount", {24'd0, ErrCount}, 32'd0);
    check("midreset_done", {31'd0, DoneRx}, 32'd0);
    exp_dout = '0;
    exp_err  = '0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    send_frame(32'h12345678, 1'b1, 1'b1);
    idle(2);

    // Saturation on the ERR_W=2 instance.
    rst2 = 1'b0;
    idle(2);
    check("sat_reset_errcount", {30'd0, s_ErrCount}, 32'd0);
    for (int unsigned k = 0; k < 5; k++) begin
      send_frame(32'h00000001, 1'b0, 1'b0);
      send_bit(1'b1);
      check($sformatf("sat_errcount_%0d", k), {30'd0, s_ErrCount}, {30'd0, sat_exp[k]});
      idle(1);
    end
    check("sat_dataout_untouched", s_DataOut, 32'd0);

    idle(4);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
